// File: rtl/text_mode_renderer_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_mode_renderer_if
//  Description : Character write bus into the text renderer's cell buffer.
//                One character per cycle while wr_en is high.
//  Revision    : 1.0 - initial release
// ============================================================================
interface text_mode_renderer_if;
  logic       wr_en;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [7:0] wr_char;

  modport master (output wr_en, wr_col, wr_row, wr_char);
  modport slave  (input  wr_en, wr_col, wr_row, wr_char);
endinterface
`default_nettype wire

// File: rtl/text_mode_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : text_mode_renderer
//  Description : Character-cell text renderer. Looks up the cell under the
//                current pixel, drives the external font ROM, serialises the
//                glyph bit, overlays a blinking cursor and delays the syncs so
//                RGB and sync leave together two cycles after pix_x/pix_y.
//  Revision    : 1.0 - initial release
// ============================================================================
module text_mode_renderer #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 60,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] FG_COLOR     = 12'hFFF,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic        SYNC_IDLE    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 pix_x,
  input  logic [9:0]                 pix_y,
  input  logic                       video_on,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  text_mode_renderer_if.slave        wr_bus,
  input  logic                       cursor_en,
  input  logic [6:0]                 cursor_col,
  input  logic [5:0]                 cursor_row,
  output logic [7:0]                 font_code,
  output logic [2:0]                 font_row,
  input  logic [7:0]                 font_pixels,
  output logic                       pixel_on,
  output logic [11:0]                rgb_out,
  output logic                       hsync_out,
  output logic                       vsync_out
);

  localparam int                DEPTH    = COLS * ROWS;
  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0]        COLS_W   = 7'(COLS);
  localparam logic [6:0]        ROWS_W   = 7'(ROWS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [7:0] buf_mem [DEPTH];

  // Stage-1 state
  logic [7:0]       char_q, char_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic             cur_q, cur_d;
  logic             oob_q, oob_d;
  logic             video_q, video_d;
  logic             hs1_q, hs1_d;
  logic             vs1_q, vs1_d;
  // Stage-2 state
  logic             pixel_on_q, pixel_on_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hs2_q, hs2_d;
  logic             vs2_q, vs2_d;
  // Cursor blink state
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_phase_q, blink_phase_d;

  logic [6:0]        cell_col, cell_row;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              wr_ok, glyph_bit, frame_start;

  // Write address decode; writes outside the COLS x ROWS grid are dropped.
  always_comb begin
    wr_ok   = wr_bus.wr_en && (wr_bus.wr_col < COLS_W) && ({1'b0, wr_bus.wr_row} < ROWS_W);
    wr_addr = ADDR_W'(wr_bus.wr_row) * COLS_A + ADDR_W'(wr_bus.wr_col);
  end

  // Buffer write port; no reset so the screen contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_mem[wr_addr] <= wr_bus.wr_char;
  end

  // Stage-1 next state: cell lookup, cursor match and sync capture.
  always_comb begin
    cell_col = pix_x[9:3];
    cell_row = pix_y[9:3];
    oob_d    = (cell_col >= COLS_W) || (cell_row >= ROWS_W);
    // Clamp the address when off-grid so the lookup never leaves the array.
    rd_addr  = oob_d ? '0 : (ADDR_W'(cell_row) * COLS_A + ADDR_W'(cell_col));
    // Sampled against the pre-edge buffer, so a same-cycle write reads old data.
    char_d   = oob_d ? 8'h00 : buf_mem[rd_addr];
    row_d    = pix_y[2:0];
    col_d    = pix_x[2:0];
    cur_d    = cursor_en && (cell_col == cursor_col) && (cell_row == {1'b0, cursor_row})
               && blink_phase_q && !oob_d;
    video_d  = video_on;
    hs1_d    = hsync_in;
    vs1_d    = vsync_in;
  end

  // Stage-2 next state: pick the glyph bit, apply cursor and blanking.
  always_comb begin
    glyph_bit  = !oob_q && (font_pixels[3'd7 - col_q] ^ cur_q);
    pixel_on_d = video_q && glyph_bit;
    rgb_d      = !video_q ? 12'h000 : (glyph_bit ? FG_COLOR : BG_COLOR);
    hs2_d      = hs1_q;
    vs2_d      = vs1_q;
  end

  // Blink timing: count frame starts, toggle visibility on counter wrap.
  always_comb begin
    frame_start   = (vsync_in != SYNC_IDLE) && (vs1_q == SYNC_IDLE);
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == CNT_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + 1'b1;
      end
    end
  end

  // Pipeline and blink registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_q        <= 8'h00;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      cur_q         <= 1'b0;
      oob_q         <= 1'b0;
      video_q       <= 1'b0;
      hs1_q         <= SYNC_IDLE;
      vs1_q         <= SYNC_IDLE;
      pixel_on_q    <= 1'b0;
      rgb_q         <= 12'h000;
      hs2_q         <= SYNC_IDLE;
      vs2_q         <= SYNC_IDLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      char_q        <= char_d;
      row_q         <= row_d;
      col_q         <= col_d;
      cur_q         <= cur_d;
      oob_q         <= oob_d;
      video_q       <= video_d;
      hs1_q         <= hs1_d;
      vs1_q         <= vs1_d;
      pixel_on_q    <= pixel_on_d;
      rgb_q         <= rgb_d;
      hs2_q         <= hs2_d;
      vs2_q         <= vs2_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign font_code = char_q;
  assign font_row  = row_q;
  assign pixel_on  = pixel_on_q;
  assign rgb_out   = rgb_q;
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;

endmodule
`default_nettype wire
